div_issue_ctrl: RTL and testbench
=================================

# div_issue_ctrl

EX-stage requester for the multi-cycle HI/LO divider. It accepts a decoded DIV/DIVU from the pipeline, latches the operands, and drives the divider's start/annul/signed handshake. It holds the pipeline stalled until the divider reports ready, then presents the remainder/quotient as a HI/LO write. It also cancels an in-flight divide cleanly on pipeline flush.

## Interface
Parameters:
- XLEN, 32, operand width; the divider result is 2*XLEN.
- CANCEL_CYC, 2, cycles spent in CANCEL before new work is accepted (min 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  DIV/DIVU present in EX this cycle.
- signed_i  in  1  1 = DIV, 0 = DIVU.
- op1_i / op2_i  in  XLEN  dividend / divisor (rs / rt values).
- flush_i  in  1  kill the EX instruction (exception/eret); wins over everything.
- ex_stall_i  in  1  stall from a later stage; EX cannot advance.
- div_start_o  out  1  to divider start_i, registered.
- div_annul_o  out  1  to divider annul_i, registered.
- div_signed_o  out  1  latched signed_i.
- div_op1_o / div_op2_o  out  XLEN  latched operands.
- div_result_i  in  2*XLEN  {remainder, quotient} from divider.
- div_ready_i  in  1  divider result valid.
- stall_req_o  out  1  stall request to pipeline control, combinational.
- hilo_we_o  out  1  HI/LO write enable travelling with the instruction.
- hi_o / lo_o  out  XLEN  div_result_i[2*XLEN-1:XLEN] / div_result_i[XLEN-1:0], captured.

## Operation
- States:
  - IDLE, BUSY, DONE, CANCEL.
  - Reset enters IDLE. Every registered output is 0 and the cancel counter is 0.
- IDLE:
  - valid_i & !flush_i:
    - Latch signed_i/op1_i/op2_i into div_signed_o/div_op*_o.
    - Set div_start_o=1 and go to BUSY.
  - Otherwise stay. Operands are not latched on flush.
- BUSY:
  - div_start_o is held at 1.
  - flush_i: go to CANCEL, div_start_o<=0, div_annul_o<=1, counter<=CANCEL_CYC-1.
  - Else div_ready_i: capture div_result_i into hi_o/lo_o, div_start_o<=0, go to DONE.
  - flush_i has priority over div_ready_i; the result is discarded.
- DONE:
  - hilo_we_o=1 with stable hi_o/lo_o.
  - Stay while ex_stall_i=1.
  - Leave to IDLE when ex_stall_i=0; that cycle the instruction advances.
  - flush_i: hilo_we_o forced 0 and go to IDLE.
  - valid_i in DONE is the same instruction and is never re-issued.
- CANCEL:
  - div_start_o=0. div_annul_o=1 in the first cycle only.
  - Count down; go to IDLE at 0.
  - Covers a divider in any state: annulled if iterating, released by start=0 if in its end state, drains if in div-by-zero.
- stall_req_o = (IDLE & valid_i & !flush_i) | BUSY | CANCEL.
  - Never asserted in DONE.
  - CANCEL stalls so a refetched instruction waits.
- Operand outputs are stable from the BUSY entry edge until the next IDLE acceptance. The divider samples them only at start.
- The controller does no arithmetic. Sign fix-up is the divider's job, and divide-by-zero passes through as HI=LO=0.

## Timing
- Cycle 0 = IDLE acceptance.
- With the companion divider:
  - Normal divide: div_start_o high from cycle 1; divider iterates cycles 2–33, fix-up at 34, end at 35; div_ready_i at 36; hilo_we_o from cycle 37.
  - stall_req_o high for cycles 0–36.
  - Divide by zero: div_ready_i at 4, hilo_we_o at 5.
- div_ready_i is honoured only in BUSY. It is ignored in IDLE/DONE/CANCEL.
- Back-to-back: after DONE exits at cycle t, a new acceptance at t+1 raises start at t+2. The divider has returned to free by then because start fell at DONE entry.
- Asynchronous reset mid-divide: outputs drop immediately, state goes to IDLE. The divider shares rst.

## Structure
- Shared CPU package holds:
  - State enum (IDLE/BUSY/DONE/CANCEL).
  - XLEN.
  - Divider handshake constants: start/stop, ready/not-ready.
- No sub-module. The divider is instantiated beside this block in the EX stage, not inside it.

## Test plan
- DIVU 100/7:
  - HI=0x2, LO=0xE; hilo_we_o at cycle 37.
  - stall_req_o high for exactly 37 cycles; one start rising edge.
- DIV 0xFFFFFFF9 / 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU x/0: HI=LO=0, hilo_we_o at cycle 5.
- flush_i at cycle 10:
  - div_annul_o pulses at 11, start low, no hilo_we_o.
  - Next DIVU 9/3 accepted after CANCEL gives LO=3, HI=0.
- ex_stall_i high for 3 cycles at DONE:
  - hilo_we_o high for 4 cycles, stable HI/LO, no second start.
- Two back-to-back DIVs (20/3, then 0x80000000/0xFFFFFFFF signed): both results correct, no lost or duplicated ready.

Source files
------------

// File: rtl/div_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl_pkg
// Shared CPU definitions for the EX-stage divider requester:
//   - CPU_XLEN      : architectural operand width
//   - div_state_e   : requester FSM state encoding
//   - DIV_START/STOP, DIV_READY/NOT_READY : divider handshake levels
// -----------------------------------------------------------------------------
package div_issue_ctrl_pkg;

  localparam int CPU_XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_DONE   = 2'd2,
    ST_CANCEL = 2'd3
  } div_state_e;

  // Divider handshake levels
  localparam logic DIV_START     = 1'b1;
  localparam logic DIV_STOP      = 1'b0;
  localparam logic DIV_READY     = 1'b1;
  localparam logic DIV_NOT_READY = 1'b0;

endpackage : div_issue_ctrl_pkg

// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
// EX-stage requester for the multi-cycle HI/LO divider. Accepts a decoded
// DIV/DIVU, latches operands, drives the divider start/annul/signed lines,
// stalls the pipeline until the divider is ready and then presents the
// {remainder, quotient} as a HI/LO write. A flush cancels an in-flight divide.
//
// Ports
//   clk, rst                 clock / asynchronous active-low reset
//   valid_i, signed_i        DIV/DIVU present in EX, 1 = signed
//   op1_i, op2_i             dividend / divisor
//   flush_i                  kill the EX instruction (highest priority)
//   ex_stall_i               later-stage stall, EX cannot advance
//   div_start_o/annul_o      divider start / annul (registered)
//   div_signed_o, div_op*_o  latched operation and operands
//   div_result_i, div_ready_i divider {rem, quot} and result-valid
//   stall_req_o              pipeline stall request (combinational)
//   hilo_we_o, hi_o, lo_o    HI/LO write enable and captured result
//   state_o                  current FSM state (debug)
//
// Handshake: div_start_o is a level. It rises on acceptance and stays high
// until the divider reports div_ready_i (seen only in BUSY) or the request is
// cancelled. Dropping start releases a divider sitting in its end state.
// div_annul_o pulses for exactly one cycle on cancel to abort an iterating
// divider. Operands are only sampled by the divider while start is high and
// are held stable from acceptance until the next acceptance.
// -----------------------------------------------------------------------------
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int XLEN       = CPU_XLEN,
  parameter int CANCEL_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              signed_i,
  input  logic [XLEN-1:0]   op1_i,
  input  logic [XLEN-1:0]   op2_i,
  input  logic              flush_i,
  input  logic              ex_stall_i,
  output logic              div_start_o,
  output logic              div_annul_o,
  output logic              div_signed_o,
  output logic [XLEN-1:0]   div_op1_o,
  output logic [XLEN-1:0]   div_op2_o,
  input  logic [2*XLEN-1:0] div_result_i,
  input  logic              div_ready_i,
  output logic              stall_req_o,
  output logic              hilo_we_o,
  output logic [XLEN-1:0]   hi_o,
  output logic [XLEN-1:0]   lo_o,
  output div_state_e        state_o
);

  // Counter wide enough to hold CANCEL_CYC-1
  localparam int CW = (CANCEL_CYC > 2) ? $clog2(CANCEL_CYC) : 1;
  localparam logic [CW-1:0] CANCEL_INIT = CW'(CANCEL_CYC - 1);

  div_state_e    state;
  logic [CW-1:0] cancel_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      div_start_o  <= DIV_STOP;
      div_annul_o  <= 1'b0;
      div_signed_o <= 1'b0;
      div_op1_o    <= '0;
      div_op2_o    <= '0;
      hi_o         <= '0;
      lo_o         <= '0;
      cancel_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid_i && !flush_i) begin
            div_signed_o <= signed_i;
            div_op1_o    <= op1_i;
            div_op2_o    <= op2_i;
            div_start_o  <= DIV_START;
            state        <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          // Flush beats a same-cycle ready: the result is dropped.
          if (flush_i) begin
            div_start_o <= DIV_STOP;
            div_annul_o <= 1'b1;
            cancel_cnt  <= CANCEL_INIT;
            state       <= ST_CANCEL;
          end else if (div_ready_i == DIV_READY) begin
            hi_o        <= div_result_i[2*XLEN-1:XLEN];
            lo_o        <= div_result_i[XLEN-1:0];
            div_start_o <= DIV_STOP;
            state       <= ST_DONE;
          end
        end

        ST_DONE: begin
          // valid_i here is the same instruction still in EX; never re-issue.
          if (flush_i || !ex_stall_i) begin
            state <= ST_IDLE;
          end
        end

        ST_CANCEL: begin
          // Annul only in the first cancel cycle; the remaining cycles let a
          // divider in any state settle before new work is accepted.
          div_annul_o <= 1'b0;
          if (cancel_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            cancel_cnt <= cancel_cnt - CW'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stall_req_o = ((state == ST_IDLE) && valid_i && !flush_i) ||
                       (state == ST_BUSY) || (state == ST_CANCEL);

  assign hilo_we_o = (state == ST_DONE) && !flush_i;

  assign state_o = state;

endmodule : div_issue_ctrl

// File: tb/tb_div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_issue_ctrl
// Directed bench for div_issue_ctrl with a behavioural companion divider:
// start seen -> ready 35 cycles later (3 cycles later for a zero divisor),
// end state held while start stays high, aborted by annul.
// -----------------------------------------------------------------------------
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              valid_i, signed_i, flush_i, ex_stall_i;
  logic [XLEN-1:0]   op1_i, op2_i;
  logic              div_start_o, div_annul_o, div_signed_o;
  logic [XLEN-1:0]   div_op1_o, div_op2_o;
  logic [2*XLEN-1:0] div_result_i;
  logic              div_ready_i;
  logic              stall_req_o, hilo_we_o;
  logic [XLEN-1:0]   hi_o, lo_o;
  div_state_e        state_o;

  div_issue_ctrl #(.XLEN(XLEN), .CANCEL_CYC(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .signed_i     (signed_i),
    .op1_i        (op1_i),
    .op2_i        (op2_i),
    .flush_i      (flush_i),
    .ex_stall_i   (ex_stall_i),
    .div_start_o  (div_start_o),
    .div_annul_o  (div_annul_o),
    .div_signed_o (div_signed_o),
    .div_op1_o    (div_op1_o),
    .div_op2_o    (div_op2_o),
    .div_result_i (div_result_i),
    .div_ready_i  (div_ready_i),
    .stall_req_o  (stall_req_o),
    .hilo_we_o    (hilo_we_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .state_o      (state_o)
  );

  // ---------------- companion divider model ----------------
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] ua, ub, uq, ur, q, r;
    if (b == 32'd0) return 64'd0;
    ua = (s && a[31]) ? -a : a;
    ub = (s && b[31]) ? -b : b;
    uq = ua / ub;
    ur = ua % ub;
    q  = (s && (a[31] ^ b[31])) ? -uq : uq;
    r  = (s && a[31]) ? -ur : ur;
    return {r, q};
  endfunction

  logic        m_run;
  int          m_cnt;
  logic [63:0] m_res;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run <= 1'b0;
      m_cnt <= 0;
      m_res <= 64'd0;
    end else if (div_annul_o) begin
      m_run <= 1'b0;
    end else if (!m_run) begin
      if (div_start_o) begin
        m_run <= 1'b1;
        m_cnt <= (div_op2_o == 32'd0) ? 2 : 34;
        m_res <= ref_div(div_signed_o, div_op1_o, div_op2_o);
      end
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end else if (!div_start_o) begin
      m_run <= 1'b0;
    end
  end

  assign div_ready_i  = (m_run && m_cnt == 0) ? DIV_READY : DIV_NOT_READY;
  assign div_result_i = m_res;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issue one divide (cycle 0 = acceptance) and run until hilo_we_o is seen.
  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input int exp_cyc);
    int          cyc, stall_cnt, rises;
    logic        prev;
    logic [63:0] exp;
    @(negedge clk);
    valid_i = 1'b1; signed_i = s; op1_i = a; op2_i = b;
    #1;
    check({tag, " stall c0"}, stall_req_o, 1'b1);
    cyc = 0; stall_cnt = 1; rises = 0; prev = div_start_o;
    while (!hilo_we_o && cyc < 200) begin
      @(negedge clk);
      valid_i = 1'b0;
      cyc++;
      #1;
      if (cyc == 1) begin
        check({tag, " start c1"}, div_start_o, 1'b1);
        check({tag, " ops latched"}, {div_signed_o, div_op1_o, div_op2_o}, {s, a, b});
      end
      if (stall_req_o) stall_cnt++;
      if (div_start_o && !prev) rises++;
      prev = div_start_o;
    end
    check({tag, " we cycle"}, cyc, exp_cyc);
    check({tag, " stall cycles"}, stall_cnt, exp_cyc);
    check({tag, " start rises"}, rises, 1);
    check({tag, " exp_q nonempty"}, (exp_q.size() != 0), 1'b1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    check({tag, " hi/lo"}, {hi_o, lo_o}, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    valid_i = 0; signed_i = 0; op1_i = 0; op2_i = 0;
    flush_i = 0; ex_stall_i = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset ctrl", {div_start_o, div_annul_o, div_signed_o, hilo_we_o, stall_req_o}, 5'b0);
    check("reset ops", {div_op1_o, div_op2_o}, 64'd0);
    check("reset hilo", {hi_o, lo_o}, 64'd0);
    check("reset state", state_o, ST_IDLE);
    @(negedge clk);
    rst = 1'b1;

    // DIVU 100/7
    exp_q.push_back({32'h2, 32'hE});
    run_div("divu100_7", 1'b0, 32'd100, 32'd7, 37);
    @(negedge clk); #1;
    check("after done we", hilo_we_o, 1'b0);
    check("after done state", state_o, ST_IDLE);

    // DIV -7/2
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 37);

    // DIVU x/0
    exp_q.push_back({32'h0, 32'h0});
    run_div("divu_by0", 1'b0, 32'h1234, 32'd0, 5);

    // Flush at cycle 10
    @(negedge clk);
    valid_i = 1'b1; signed_i = 1'b0; op1_i = 32'd100; op2_i = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      valid_i = 1'b0;
      if (c == 10) flush_i = 1'b1;
    end
    #1;
    check("flush c10 stall", stall_req_o, 1'b1);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush c11 annul", div_annul_o, 1'b1);
    check("flush c11 start", div_start_o, 1'b0);
    check("flush c11 we", hilo_we_o, 1'b0);
    check("flush c11 state", state_o, ST_CANCEL);
    @(negedge clk); #1;
    check("flush c12 annul", div_annul_o, 1'b0);
    check("flush c12 stall", stall_req_o, 1'b1);
    @(negedge clk); #1;
    check("flush c13 stall", stall_req_o, 1'b0);
    check("flush c13 state", state_o, ST_IDLE);
    check("flush c13 we", hilo_we_o, 1'b0);
    exp_q.push_back({32'h0, 32'h3});
    run_div("divu9_3", 1'b0, 32'd9, 32'd3, 37);

    // ex_stall held for 3 cycles at DONE
    exp_q.push_back({32'h2, 32'h6});
    run_div("divu50_8", 1'b0, 32'd50, 32'd8, 37);
    ex_stall_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      check("exstall we", hilo_we_o, 1'b1);
      check("exstall hilo", {hi_o, lo_o}, {32'h2, 32'h6});
      check("exstall no start", div_start_o, 1'b0);
      check("exstall no stall_req", stall_req_o, 1'b0);
      if (k == 3) ex_stall_i = 1'b0;
    end
    @(negedge clk); #1;
    check("exstall release we", hilo_we_o, 1'b0);

    // Back-to-back signed divides
    exp_q.push_back({32'h2, 32'h6});
    run_div("div20_3", 1'b1, 32'd20, 32'd3, 37);
    exp_q.push_back({32'h0, 32'h80000000});
    run_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 37);

    // Flush while in DONE suppresses the write
    exp_q.push_back({32'h0, 32'h0});
    run_div("divu7_0", 1'b0, 32'd7, 32'd0, 5);
    flush_i = 1'b1;
    #1;
    check("done flush we", hilo_we_o, 1'b0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("done flush state", state_o, ST_IDLE);

    // Asynchronous reset mid-divide
    @(negedge clk);
    valid_i = 1'b1; signed_i = 1'b1; op1_i = 32'd100; op2_i = 32'd7;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("pre-reset start", div_start_o, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async rst ctrl", {div_start_o, div_annul_o, div_signed_o, stall_req_o}, 4'b0);
    check("async rst ops", {div_op1_o, div_op2_o}, 64'd0);
    check("async rst state", state_o, ST_IDLE);
    @(negedge clk);
    rst = 1'b1;

    // Recovery after reset
    exp_q.push_back({32'h1, 32'h4});
    run_div("divu9_2", 1'b0, 32'd9, 32'd2, 37);
    check("exp_q drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_div_issue_ctrl
